fifo_30_cycle_dispatch: RTL
===========================

# fifo_30_cycle_dispatch

Downstream counterpart of the 30-channel cycle-check collector: it accepts the 64-bit `up_data` / `data_valid` word stream the collector emits, decodes the channel index carried in each word, and writes the 32-bit payload into one of 30 per-channel FIFOs. Each channel is drained independently by its consumer through its own read request. Malformed words, and words addressed to a full channel, are dropped and counted. The block sits at the receive end of the uplink, directly after the link deframer.

## Interface
Parameters:
- `CH_NUM`, 30: number of channels.
- `DATA_W`, 32: payload width per channel.
- `DEPTH`, 8: words per channel FIFO; must be a power of two.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `data_valid`  in  1  an input word is present this cycle; no backpressure exists.
- `up_data`  in  64  input word: [63:40] reserved, must be 0; [39:32] channel index 0..CH_NUM-1; [31:0] payload.
- `fifo_rdreq`  in  CH_NUM  per-channel read request.
- `fifo_data_out`  out  CH_NUM*DATA_W  per-channel read data; channel t occupies [t*32+31 : t*32].
- `fifo_rd_valid`  out  CH_NUM  1-cycle pulse, per channel: the read data was updated this cycle.
- `fifo_empty`  out  CH_NUM  per-channel empty flag.
- `fifo_full`  out  CH_NUM  per-channel full flag.
- `drop_pulse`  out  1  1-cycle pulse when a word is discarded.
- `drop_cnt`  out  16  saturating count of discarded words.

## Operation
- **Stage 1 (input register):** every cycle, capture `data_valid` and `up_data` into s1 registers. The block accepts a word every cycle.
- **Stage 2 (decode and write):**
  - `ch = s1_data[39:32]`.
  - The word is legal when s1_valid is 1, reserved bits [63:40] are 0, and ch < CH_NUM.
  - A legal word to a non-full channel is written to FIFO[ch]: write pointer +1, count +1.
  - Drop conditions: illegal word; or legal word with count[ch]==DEPTH at the start of the cycle.
  - A write to a full channel drops even if `fifo_rdreq[ch]` is asserted in the same cycle. "Full" is evaluated on the pre-read count.
  - On drop: `drop_pulse` = 1 for one cycle; `drop_cnt` +1, saturating at 16'hFFFF.
- **Read (per channel t, independent):**
  - `fifo_rdreq[t]` with count[t] > 0: the head word goes to `fifo_data_out[t]` on the next edge; `fifo_rd_valid[t]` pulses; read pointer +1.
  - `fifo_rdreq[t]` with count[t] == 0 is ignored: no pulse, data unchanged, no error.
  - `fifo_data_out[t]` holds its last read value until the next successful read.
- **Simultaneous write and read on the same channel:** count is unchanged, both pointers advance.
  - On an empty channel the read is ignored and the write proceeds. No fall-through.
- **Pointers:** log2(DEPTH)-bit, wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Flags:** `fifo_empty[t]` = (count==0); `fifo_full[t]` = (count==DEPTH). Both are decoded from registered count.

## Timing
- Reset values, while `rst_n` is low at a clock edge:
  - s1 cleared; all pointers and counts 0.
  - `fifo_empty` = all 1; `fifo_full` = 0.
  - `fifo_data_out` = 0; `fifo_rd_valid` = 0.
  - `drop_pulse` = 0; `drop_cnt` = 0.
- Reset mid-operation discards all stored and in-flight words.
- Write latency: `data_valid` sampled at edge N → stored at edge N+1 → `fifo_empty[ch]` falls in the cycle after edge N+1. The earliest read request is in that cycle.
- Read latency: `fifo_rdreq[t]` sampled at edge M → `fifo_data_out[t]` and `fifo_rd_valid[t]` valid after edge M.
- Drop report: `drop_pulse` and `drop_cnt` update at edge N+1 for a word sampled at edge N.
- Sustained throughput: one input word per cycle; one read per channel per cycle.

## Structure
- Package `fifo30_pkg`, shared with the collector:
  - CH_NUM, DATA_W.
  - Field positions: CH_LSB=32, CH_MSB=39, RSV_LSB=40.
  - Drop counter width.
- Sub-module `dispatch_ch_fifo`:
  - One synchronous FIFO with write enable, read request, registered output, and empty/full.
  - Instantiated CH_NUM times in a generate loop.
  - The top level contains only stage 1, the decode, and the drop logic.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 cycles with `data_valid`=1 → `fifo_empty` = all ones, `drop_cnt`=0, no `fifo_rd_valid`.
- **Single word:** `up_data`=64'h0000_0005_0000_1234 for 1 cycle → `fifo_empty[5]` falls 2 cycles later. Then `fifo_rdreq[5]` → next cycle `fifo_data_out[5]`=32'h1234, `fifo_rd_valid[5]`=1, `fifo_empty[5]`=1.
- **Overflow:** 9 back-to-back words to channel 0 (payloads 1..9) → `fifo_full[0]`=1 and `drop_cnt`=1. Reading 8 times returns 1..8 in order.
- **Illegal words:** ch=30, ch=255, and a word with bit 40 set → 3 `drop_pulse`s, `drop_cnt`=3, no FIFO written.
- **Simultaneous read/write:** channel 7 holds 3 words; write and read in the same cycle → count stays 3 and the oldest word is read. The same case on an empty channel → the write lands and no `fifo_rd_valid[7]`.
- **Interleaved load:** random legal words on all 30 channels with random reads → per-channel scoreboard matches exactly, and `drop_cnt` equals the model's count of writes to full channels.

Source files
------------

// File: rtl/fifo30_pkg.sv
// Shared constants for the 30-channel uplink word format (collector and dispatcher).
package fifo30_pkg;
  localparam int CH_NUM     = 30;
  localparam int DATA_W     = 32;
  localparam int WORD_W     = 64;
  localparam int CH_LSB     = 32;
  localparam int CH_MSB     = 39;
  localparam int RSV_LSB    = 40;
  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/dispatch_ch_fifo.sv
// Single-channel synchronous FIFO with registered read data and a one-cycle read-valid pulse.
module dispatch_ch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              do_wr, do_rd;

  // Flags come from the registered count, so full/empty reflect the state before this edge.
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_wr      = wr_en_i && !full_o;
  assign do_rd      = rd_req_i && !empty_o;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage needs no reset: the zeroed pointers and count make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/fifo_30_cycle_dispatch.sv
// Uplink receive dispatcher: registers each incoming word, decodes its channel and
// writes the payload into that channel's FIFO, dropping and counting bad or blocked words.
module fifo_30_cycle_dispatch #(
  parameter int CH_NUM = fifo30_pkg::CH_NUM,
  parameter int DATA_W = fifo30_pkg::DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         data_valid,
  input  logic [fifo30_pkg::WORD_W-1:0] up_data,
  input  logic [CH_NUM-1:0]            fifo_rdreq,
  output logic [CH_NUM*DATA_W-1:0]     fifo_data_out,
  output logic [CH_NUM-1:0]            fifo_rd_valid,
  output logic [CH_NUM-1:0]            fifo_empty,
  output logic [CH_NUM-1:0]            fifo_full,
  output logic                         drop_pulse,
  output logic [fifo30_pkg::DROP_CNT_W-1:0] drop_cnt
);
  import fifo30_pkg::*;

  logic                   s1_valid_q;
  logic [WORD_W-1:0]      s1_data_q;
  logic [CH_MSB-CH_LSB:0] ch;
  logic                   legal, ch_full, drop;
  logic [CH_NUM-1:0]      wr_en;
  logic                   drop_pulse_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign ch    = s1_data_q[CH_MSB:CH_LSB];
  assign legal = s1_valid_q && (s1_data_q[WORD_W-1:RSV_LSB] == '0) && (int'(ch) < CH_NUM);

  // Full is judged on the pre-read count, so a same-cycle read never rescues a full channel.
  always_comb begin
    ch_full = 1'b0;
    wr_en   = '0;
    for (int t = 0; t < CH_NUM; t++) begin
      if (int'(ch) == t) begin
        ch_full  = fifo_full[t];
        wr_en[t] = legal && !fifo_full[t];
      end
    end
  end

  assign drop       = s1_valid_q && (!legal || ch_full);
  assign drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      s1_valid_q   <= data_valid;
      s1_data_q    <= up_data;
      drop_pulse_q <= drop;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    dispatch_ch_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (s1_data_q[DATA_W-1:0]),
      .rd_req_i  (fifo_rdreq[g]),
      .rd_data_o (fifo_data_out[g*DATA_W +: DATA_W]),
      .rd_valid_o(fifo_rd_valid[g]),
      .empty_o   (fifo_empty[g]),
      .full_o    (fifo_full[g])
    );
  end
endmodule
